// File: rtl/btn_debounce_if.sv
// Button debouncer bus: raw pin in, debounced level and event strobes out.
// The master side drives the pin and consumes strobes; the slave side is the debouncer.
interface btn_debounce_if;
  logic       btn_raw;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       repeat_pulse;
  logic [1:0] dbg_state;

  // Strobes are single-cycle events with no back-pressure: the consumer samples
  // press/release/repeat every cycle, and at most one of them is high at a time.
  modport master (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse,
    input  dbg_state
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output repeat_pulse,
    output dbg_state
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, press/release strobes.
// Optional auto-repeat strobes are built only when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce #(
  parameter int unsigned DB_CYCLES     = 500000,
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 12500000,
  parameter int unsigned REPEAT_PERIOD = 2500000
) (
  input  logic          clk,
  input  logic          rst_in,
  btn_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam int unsigned DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("btn_debounce: DB_CYCLES must be >= 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_repeat_period
    $error("btn_debounce: REPEAT_PERIOD must be >= 2");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_repeat_delay
    $error("btn_debounce: REPEAT_DELAY must be >= 1");
  end

  logic raw_pol;
  logic sync1_q;
  logic sync2_q;
  logic s_in;

  assign raw_pol = ACTIVE_LOW ? ~bus.btn_raw : bus.btn_raw;
  assign s_in    = sync2_q;

  // Both stages reset inactive so a button held through reset is seen as a fresh press.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_pol;
      sync2_q <= sync1_q;
    end
  end

  state_e            state_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic              level_q;
  logic              press_q;
  logic              release_q;
  logic              accept_press;

  assign accept_press = (state_q == PRESS_WAIT) && s_in && (db_cnt_q == DB_LAST);

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q   <= IDLE;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE: begin
          db_cnt_q <= '0;
          if (s_in) begin
            state_q <= PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!s_in) begin
            state_q  <= IDLE;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q  <= PRESSED;
            db_cnt_q <= '0;
            press_q  <= 1'b1;
            level_q  <= 1'b1;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          db_cnt_q <= '0;
          if (!s_in) begin
            state_q <= RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          // A return to active here is bounce: level stays high and no new press is reported.
          if (s_in) begin
            state_q  <= PRESSED;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q   <= IDLE;
            db_cnt_q  <= '0;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          db_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.dbg_state     = state_q;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_periodic_q;
  logic             repeat_q;
  logic [REP_W-1:0] rep_last;

  assign rep_last = rep_periodic_q ? PERIOD_LAST : DELAY_LAST;

  // Counting only happens while PRESSED and still active, so a repeat due on the
  // edge that leaves PRESSED is dropped and the count freezes across a release bounce.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      rep_cnt_q      <= '0;
      rep_periodic_q <= 1'b0;
      repeat_q       <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rep_cnt_q      <= '0;
          rep_periodic_q <= 1'b0;
        end
        PRESS_WAIT: begin
          if (accept_press) begin
            rep_cnt_q      <= '0;
            rep_periodic_q <= 1'b0;
          end
        end
        PRESSED: begin
          if (s_in) begin
            if (rep_cnt_q == rep_last) begin
              repeat_q       <= 1'b1;
              rep_cnt_q      <= '0;
              rep_periodic_q <= 1'b1;
            end else begin
              rep_cnt_q <= rep_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          rep_cnt_q <= rep_cnt_q;
        end
      endcase
    end
  end

  assign bus.repeat_pulse = repeat_q;
`else
  assign bus.repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: an active-high and an active-low instance see the same
// (mirrored) pin, and a negedge monitor checks both against one expected-event queue.
module tb_btn_debounce;
  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int LAT = DB + 3;
  localparam int W   = 34;

  localparam logic [1:0] K_PRESS   = 2'd1;
  localparam logic [1:0] K_RELEASE = 2'd2;
  localparam logic [1:0] K_REPEAT  = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic raw = 1'b1;
  int   cyc = 0;

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btn_debounce_if bus_hi ();
  btn_debounce_if bus_lo ();

  assign bus_hi.btn_raw = raw;
  assign bus_lo.btn_raw = ~raw;

  btn_debounce #(
    .DB_CYCLES(DB), .ACTIVE_LOW(1'b0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_hi (
    .clk   (clk),
    .rst_in(rst_in),
    .bus   (bus_hi.slave)
  );

  btn_debounce #(
    .DB_CYCLES(DB), .ACTIVE_LOW(1'b1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_lo (
    .clk   (clk),
    .rst_in(rst_in),
    .bus   (bus_lo.slave)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_level = 1'b0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] kind, input int at);
    exp_q.push_back({kind, 32'(at)});
  endtask

  always @(negedge clk) begin
    logic [W-1:0] front;
    logic [2:0]   exp_vec;
    if (rst_in) begin
      exp_level = 1'b0;
      check("reset_outputs_hi", {bus_hi.btn_level, bus_hi.press_pulse, bus_hi.release_pulse, bus_hi.repeat_pulse}, 4'b0000);
      check("reset_outputs_lo", {bus_lo.btn_level, bus_lo.press_pulse, bus_lo.release_pulse, bus_lo.repeat_pulse}, 4'b0000);
    end else begin
      while (exp_q.size() > 0 && int'(exp_q[0][31:0]) < cyc) begin
        front = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missing_event: kind %0d expected at cycle %0d, not seen by cycle %0d",
                 front[33:32], front[31:0], cyc);
      end
      exp_vec = 3'b000;
      if (exp_q.size() > 0 && int'(exp_q[0][31:0]) == cyc) begin
        front = exp_q.pop_front();
        case (front[33:32])
          K_PRESS:   begin exp_vec = 3'b100; exp_level = 1'b1; end
          K_RELEASE: begin exp_vec = 3'b010; exp_level = 1'b0; end
          K_REPEAT:  exp_vec = 3'b001;
          default:   exp_vec = 3'b000;
        endcase
      end
      check("strobes_hi", {1'b0, bus_hi.press_pulse, bus_hi.release_pulse, bus_hi.repeat_pulse}, {1'b0, exp_vec});
      check("strobes_lo", {1'b0, bus_lo.press_pulse, bus_lo.release_pulse, bus_lo.repeat_pulse}, {1'b0, exp_vec});
      check("level_hi", {3'b000, bus_hi.btn_level}, {3'b000, exp_level});
      check("level_lo", {3'b000, bus_lo.btn_level}, {3'b000, exp_level});
    end
  end

  // driver tasks; called on a negedge, pin changes take effect from the next posedge
  task automatic do_press(input bit pre_high, input int hold, input bit bounce);
    int c;
    int p;
    int d;
    c = cyc;
    if (!pre_high) raw = 1'b1;
    p = c + LAT;
    push(K_PRESS, p);
    d = c + hold;
`ifdef BTN_AUTO_REPEAT_EN
    for (int t = p + RD; t <= d + 2; t += RP) push(K_REPEAT, t);
`endif
    repeat (hold) @(negedge clk);
    raw = 1'b0;
    if (bounce) begin
      repeat (2) @(negedge clk);
      raw = 1'b1;
      @(negedge clk);
      raw = 1'b0;
      push(K_RELEASE, d + 3 + LAT);
    end else begin
      push(K_RELEASE, d + LAT);
    end
    repeat (LAT + 14) @(negedge clk);
  endtask

  task automatic glitch(input int n);
    raw = 1'b1;
    repeat (n) @(negedge clk);
    raw = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    // button held through three reset cycles counts as a press afterwards
    raw = 1'b1;
    repeat (3) @(negedge clk);
    rst_in = 1'b0;
    do_press(1'b1, 30, 1'b0);

    // clean press / release
    do_press(1'b0, 30, 1'b0);

    // short pulses are rejected
    glitch(3);
    glitch(1);

    // release bounce
    do_press(1'b0, 12, 1'b1);

    // long hold exercising auto-repeat
    do_press(1'b0, LAT + 46, 1'b0);

    // press bounce, then a stable press
    raw = 1'b1;
    repeat (2) @(negedge clk);
    raw = 1'b0;
    @(negedge clk);
    do_press(1'b0, 10, 1'b0);

    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [W-1:0] left;
      left = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL leftover_event: kind %0d expected at cycle %0d, never seen", left[33:32], left[31:0]);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
